// File: rtl/shared_reg_wr_arbiter.sv
// rtl/shared_reg_wr_arbiter.sv - round-robin write arbiter for a shared register wall (optional bursts: LOCK_EN)
module shared_reg_wr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int LENGTH   = 5,
  parameter int MAX_LOCK = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*LENGTH-1:0] wr_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      reg_en,
  output logic [LENGTH-1:0]         reg_d,
  output logic                      busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [PW:0]   NREQ_W   = (PW + 1)'(NUM_REQ);

  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          rr_ptr_nxt;
  logic [2*NUM_REQ-1:0]   req_dbl;
  logic [NUM_REQ-1:0]     req_rot;
  logic [PW-1:0]          pick_off;
  logic [PW:0]            pick_sum;
  logic                   pick_vld;
  logic [PW-1:0]          pick_idx;
  logic [PW-1:0]          pick_adv;
  logic [NUM_REQ-1:0]     arb_gnt;
  logic [LENGTH-1:0]      sel_data;

  // Round-robin pick: rotate req so rr_ptr sits at bit 0, take the lowest set bit, rotate back
  always_comb begin
    req_dbl  = {req, req} >> rr_ptr;
    req_rot  = req_dbl[NUM_REQ-1:0];
    pick_vld = 1'b0;
    pick_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_vld = 1'b1;
        pick_off = PW'(k);
      end
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
    if (pick_sum >= NREQ_W) begin
      pick_sum = pick_sum - NREQ_W;
    end
    pick_idx = pick_sum[PW-1:0];
    pick_adv = (pick_idx == LAST_IDX) ? '0 : pick_idx + PW'(1);
    arb_gnt  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_gnt[i] = pick_vld && (pick_idx == PW'(i));
    end
  end

`ifdef LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [PW-1:0]  owner;
  logic [PW-1:0]  owner_nxt;
  logic [CW-1:0]  lock_cnt;
  logic [CW-1:0]  lock_cnt_nxt;
  logic           hold;

  // A burst continues only while its owner keeps both req and lock up
  assign hold = (state == LOCKED) && req[owner] && lock[owner];
  assign busy = hold;

  // Next-state and grant: burst owner wins outright, otherwise fall straight into round robin
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    lock_cnt_nxt = lock_cnt;
    rr_ptr_nxt   = rr_ptr;
    gnt          = '0;
    if (hold) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        gnt[i] = (owner == PW'(i));
      end
      lock_cnt_nxt = lock_cnt + CW'(1);
      if (lock_cnt + CW'(1) == CW'(MAX_LOCK)) begin
        state_nxt = ARB;
      end
    end else begin
      state_nxt = ARB;
      gnt       = arb_gnt;
      if (pick_vld) begin
        rr_ptr_nxt = pick_adv;
        if (lock[pick_idx] && (MAX_LOCK > 1)) begin
          state_nxt    = LOCKED;
          owner_nxt    = pick_idx;
          lock_cnt_nxt = CW'(1);
        end
      end
    end
  end

  // Arbiter state register
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      state    <= ARB;
      owner    <= '0;
      lock_cnt <= '0;
    end else begin
      rr_ptr   <= rr_ptr_nxt;
      state    <= state_nxt;
      owner    <= owner_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = ^lock;
  assign busy        = 1'b0;

  // Plain round robin: every grant advances the pointer past the winner
  always_comb begin
    gnt        = arb_gnt;
    rr_ptr_nxt = pick_vld ? pick_adv : rr_ptr;
  end

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
    end
  end
`endif

  // Select the granted requester's data slice
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_data = wr_data[i*LENGTH +: LENGTH];
      end
    end
  end

  // Write stage: one register between the grant and the wall; data holds when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_en <= 1'b0;
      reg_d  <= '0;
    end else begin
      reg_en <= |gnt;
      if (|gnt) begin
        reg_d <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_wr_arbiter.sv
// tb/tb_shared_reg_wr_arbiter.sv - scoreboard bench for shared_reg_wr_arbiter (honours LOCK_EN)
module tb_shared_reg_wr_arbiter;

  localparam int N  = 4;
  localparam int L  = 5;
  localparam int ML = 4;
`ifdef LOCK_EN
  localparam bit LOCKING = 1'b1;
`else
  localparam bit LOCKING = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   lock = '0;
  logic [N*L-1:0] wr_data = '0;
  logic [N-1:0]   gnt;
  logic           reg_en;
  logic [L-1:0]   reg_d;
  logic           busy;

  always #5 clk = ~clk;

  shared_reg_wr_arbiter #(.NUM_REQ(N), .LENGTH(L), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .wr_data(wr_data),
    .gnt(gnt), .reg_en(reg_en), .reg_d(reg_d), .busy(busy)
  );

  typedef struct {
    bit           care;
    logic [N-1:0] gnt;
    logic         busy;
    logic [N-1:0] req;
  } gexp_t;

  typedef struct {
    logic         en;
    logic [L-1:0] d;
  } wexp_t;

  gexp_t q_g[$];
  wexp_t q_w[$];
  gexp_t ge;
  wexp_t we;
  int checks = 0;
  int errors = 0;

  int           m_next   = 0;
  bit           m_locked = 1'b0;
  int           m_owner  = 0;
  int           m_burst  = 0;
  logic [L-1:0] m_d      = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One cycle of stimulus; the reference model predicts this cycle's grant and next cycle's wall inputs
  task automatic drive(input bit r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                       input logic [N*L-1:0] d, output logic [N-1:0] g);
    gexp_t e;
    wexp_t w;
    int    win;
    int    idx;
    @(posedge clk);
    #1;
    reset   = r;
    req     = rq;
    lock    = lk;
    wr_data = d;
    g       = '0;
    e.req   = rq;
    e.busy  = m_locked && rq[m_owner] && lk[m_owner];
    if (r) begin
      e.care   = 1'b0;
      m_next   = 0;
      m_locked = 1'b0;
      m_owner  = 0;
      m_burst  = 0;
      m_d      = '0;
      w.en     = 1'b0;
      w.d      = '0;
    end else begin
      e.care = 1'b1;
      if (m_locked && rq[m_owner] && lk[m_owner]) begin
        g[m_owner] = 1'b1;
        m_burst++;
        if (m_burst == ML) m_locked = 1'b0;
      end else begin
        m_locked = 1'b0;
        win = -1;
        for (int k = 0; k < N; k++) begin
          idx = (m_next + k) % N;
          if (win < 0 && rq[idx]) win = idx;
        end
        if (win >= 0) begin
          g[win] = 1'b1;
          m_next = (win + 1) % N;
          if (LOCKING && lk[win] && ML > 1) begin
            m_locked = 1'b1;
            m_owner  = win;
            m_burst  = 1;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (g[i]) m_d = d[i*L +: L];
      end
      w.en = |g;
      w.d  = m_d;
    end
    e.gnt = g;
    q_g.push_back(e);
    q_w.push_back(w);
  endtask

  // Monitor: compare the grant of the current cycle and the registered wall inputs
  always @(negedge clk) begin
    if (q_g.size() > 0) begin
      ge = q_g.pop_front();
      if (ge.care) begin
        chk("gnt", 32'(gnt), 32'(ge.gnt));
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("gnt_implies_req", 32'(gnt & ~ge.req), 32'd0);
      end
      chk("busy", 32'(busy), 32'(ge.busy));
    end
    if (q_w.size() > 0) begin
      we = q_w.pop_front();
      chk("reg_en", 32'(reg_en), 32'(we.en));
      chk("reg_d", 32'(reg_d), 32'(we.d));
    end
  end

  logic [N*L-1:0] d1;
  logic [N-1:0]   g;
  logic [N-1:0]   pend;
  logic [N*L-1:0] pdata;
  logic [N-1:0]   lkreg;

  initial begin
    we.en = 1'b0;
    we.d  = '0;
    q_w.push_back(we);
    d1 = {5'h13, 5'h12, 5'h11, 5'h10};

    drive(1'b1, '0, '0, '0, g);
    for (int c = 0; c < 4; c++) drive(1'b0, 4'b1111, 4'b0000, d1, g);
    for (int c = 0; c < 5; c++) drive(1'b0, 4'b0100, 4'b0000, d1, g);
    for (int c = 0; c < 2; c++) drive(1'b0, 4'b1001, 4'b0000, d1, g);
    drive(1'b0, 4'b0010, 4'b0000, {5'h00, 5'h00, 5'h1A, 5'h00}, g);
    for (int c = 0; c < 2; c++) drive(1'b0, 4'b0000, 4'b0000, d1, g);

    drive(1'b1, '0, '0, '0, g);
    for (int c = 0; c < 8; c++) drive(1'b0, 4'b1111, 4'b0001, d1, g);

    drive(1'b1, '0, '0, '0, g);
    drive(1'b0, 4'b0011, 4'b0000, d1, g);
    drive(1'b0, 4'b0100, 4'b0100, d1, g);
    drive(1'b0, 4'b0100, 4'b0100, d1, g);
    drive(1'b0, 4'b1111, 4'b0000, d1, g);
    drive(1'b0, 4'b1111, 4'b0000, d1, g);

    drive(1'b1, '0, '0, '0, g);
    drive(1'b0, 4'b1111, 4'b0001, d1, g);
    drive(1'b0, 4'b1111, 4'b0001, d1, g);
    drive(1'b1, 4'b1111, 4'b0001, d1, g);
    drive(1'b0, 4'b1111, 4'b0000, d1, g);
    drive(1'b0, 4'b0000, 4'b0000, d1, g);

    pend  = '0;
    pdata = '0;
    lkreg = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]          = 1'b1;
          pdata[i*L +: L]  = L'($urandom);
        end
        if ($urandom_range(0, 3) == 0) lkreg[i] = ~lkreg[i];
      end
      if ($urandom_range(0, 63) == 0) begin
        drive(1'b1, pend, lkreg, pdata, g);
      end else begin
        drive(1'b0, pend, lkreg, pdata, g);
        pend = pend & ~g;
      end
    end

    for (int c = 0; c < 3; c++) drive(1'b0, '0, '0, '0, g);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queues_drained", 32'(q_g.size() + q_w.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
